// File: rtl/hazard_tnew_tracker_if.sv
// hazard_tnew_tracker_if
//   Groups the D-stage decoder fields feeding the hazard tracker and the
//   stall / forwarding-select outputs returned to the pipeline.
//   master : decoder / pipeline side (drives D fields, receives selects)
//   slave  : hazard_tnew_tracker side
//   D fields   : rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
//                we_d, wa_d, tnew_d, md_start_d, md_div_d, md_use_d
//   Results    : stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
interface hazard_tnew_tracker_if #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TW     = 2,
    parameter int unsigned SW     = $clog2(NSTAGE + 1)
);
    logic [4:0]    rs_d;
    logic [4:0]    rt_d;
    logic          use_rs_d;
    logic          use_rt_d;
    logic [TW-1:0] tuse_rs_d;
    logic [TW-1:0] tuse_rt_d;
    logic          we_d;
    logic [4:0]    wa_d;
    logic [TW-1:0] tnew_d;
    logic          md_start_d;
    logic          md_div_d;
    logic          md_use_d;

    logic          stall;
    logic [SW-1:0] fwd_rs_d;
    logic [SW-1:0] fwd_rt_d;
    logic [SW-1:0] fwd_rs_e;
    logic [SW-1:0] fwd_rt_e;
    logic          md_busy;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
        output we_d, wa_d, tnew_d, md_start_d, md_div_d, md_use_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
        input  we_d, wa_d, tnew_d, md_start_d, md_div_d, md_use_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );
endinterface

// File: rtl/hazard_tnew_tracker.sv
// hazard_tnew_tracker
//   Tracks every in-flight register write in a descriptor shift register (one
//   entry per post-decode stage, 1=E .. NSTAGE) with a Tnew countdown, and
//   derives the D-stage stall plus D/E forwarding selects. Optionally tracks
//   multiply/divide occupancy.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low
//     bus   : hazard_tnew_tracker_if.slave (D fields in, stall/fwd/md_busy out)
//   Configuration:
//     HAZARD_MDU_EN defined   -> MDU busy counter and MDU stall are built.
//     HAZARD_MDU_EN undefined -> md_* inputs ignored, md_busy tied low.
//   Note: MUL_LAT must not exceed DIV_LAT (counter is sized for DIV_LAT).
module hazard_tnew_tracker #(
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned TW      = 2,
    parameter int unsigned SW      = $clog2(NSTAGE + 1),
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_tnew_tracker_if.slave bus
);
    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    // Descriptor shift register, index 1 = E stage
    logic [NSTAGE:1] r_valid;
    logic [NSTAGE:1] r_we;
    logic [4:0]      r_wa   [1:NSTAGE];
    logic [TW-1:0]   r_tnew [1:NSTAGE];
    // Source registers of the instruction in E (stage 1 only)
    logic [4:0]      r_rs_e;
    logic [4:0]      r_rt_e;

    logic            w_stall;
    logic            w_stall_rs;
    logic            w_stall_rt;
    logic            w_stall_md;
    logic            w_md_busy;
    logic [NSTAGE:1] w_live;
    logic [SW-1:0]   w_fwd_rs_d;
    logic [SW-1:0]   w_fwd_rt_d;
    logic [SW-1:0]   w_fwd_rs_e;
    logic [SW-1:0]   w_fwd_rt_e;

    // A stage can only ever match a non-zero source when it writes a
    // non-zero destination, so the r!=0 test folds into the descriptor.
    always_comb begin
        w_live = '0;
        for (int k = 1; k <= NSTAGE; k++) begin
            w_live[k] = r_valid[k] & r_we[k] & (r_wa[k] != 5'd0);
        end
    end

    // D-stage selects and stall: walk oldest to youngest so the youngest
    // (lowest-indexed) match is the one left standing.
    always_comb begin
        w_fwd_rs_d = '0;
        w_fwd_rt_d = '0;
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (w_live[k] && (r_wa[k] == bus.rs_d)) begin
                w_fwd_rs_d = (r_tnew[k] == '0) ? SW'(k) : '0;
                w_stall_rs = bus.use_rs_d && (r_tnew[k] > bus.tuse_rs_d);
            end
            if (w_live[k] && (r_wa[k] == bus.rt_d)) begin
                w_fwd_rt_d = (r_tnew[k] == '0) ? SW'(k) : '0;
                w_stall_rt = bus.use_rt_d && (r_tnew[k] > bus.tuse_rt_d);
            end
        end
    end

    // E-stage selects: only stages past E whose result already exists count.
    always_comb begin
        w_fwd_rs_e = '0;
        w_fwd_rt_e = '0;
        for (int k = NSTAGE; k >= 2; k--) begin
            if (w_live[k] && (r_tnew[k] == '0) && (r_wa[k] == r_rs_e)) begin
                w_fwd_rs_e = SW'(k);
            end
            if (w_live[k] && (r_tnew[k] == '0) && (r_wa[k] == r_rt_e)) begin
                w_fwd_rt_e = SW'(k);
            end
        end
    end

    assign w_stall = w_stall_rs | w_stall_rt | w_stall_md;

    // Stage 1 takes the D descriptor or an all-zero bubble; older stages
    // shift with a saturating Tnew countdown. Stage NSTAGE falls off the end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_we    <= '0;
            r_rs_e  <= '0;
            r_rt_e  <= '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                r_wa[k]   <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            r_valid[1] <= ~w_stall;
            r_we[1]    <= bus.we_d & ~w_stall;
            r_wa[1]    <= w_stall ? 5'd0 : bus.wa_d;
            r_tnew[1]  <= w_stall ? '0 : bus.tnew_d;
            r_rs_e     <= w_stall ? 5'd0 : bus.rs_d;
            r_rt_e     <= w_stall ? 5'd0 : bus.rt_d;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_wa[k]    <= r_wa[k-1];
                r_tnew[k]  <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TW'(1)) : '0;
            end
        end
    end

`ifdef HAZARD_MDU_EN
    logic          r_md_start_e;
    logic          r_md_div_e;
    logic [CW-1:0] r_md_cnt;
    logic          w_md_start_e;

    assign w_md_start_e = r_valid[1] & r_md_start_e;

    // The cycle a start sits in E already counts as busy; the counter
    // covers the LAT cycles after it leaves E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_start_e <= 1'b0;
            r_md_div_e   <= 1'b0;
            r_md_cnt     <= '0;
        end else begin
            r_md_start_e <= bus.md_start_d & ~w_stall;
            r_md_div_e   <= bus.md_div_d & ~w_stall;
            if (w_md_start_e) begin
                r_md_cnt <= r_md_div_e ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - CW'(1);
            end
        end
    end

    assign w_md_busy  = (r_md_cnt != '0) | w_md_start_e;
    assign w_stall_md = (bus.md_use_d | bus.md_start_d) & w_md_busy;
`else
    logic w_unused_md;
    assign w_unused_md = ^{bus.md_start_d, bus.md_div_d, bus.md_use_d, CW'(MUL_LAT)};
    assign w_md_busy   = 1'b0;
    assign w_stall_md  = 1'b0;
`endif

    assign bus.stall    = w_stall;
    assign bus.fwd_rs_d = w_fwd_rs_d;
    assign bus.fwd_rt_d = w_fwd_rt_d;
    assign bus.fwd_rs_e = w_fwd_rs_e;
    assign bus.fwd_rt_e = w_fwd_rt_e;
    assign bus.md_busy  = w_md_busy;
endmodule
